// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator: qualifies an asynchronous FCW, accumulates it into a
// phase register and derives the ROM address, square wave and wrap pulse.
module dds_phase_accumulator #(
   parameter int unsigned      ACC_W      = 32,
   parameter int unsigned      ADDR_W     = 10,
   parameter logic [ACC_W-1:0] STEP_RESET = ACC_W'(171798691),
   parameter int unsigned      STABLE_N   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [ACC_W-1:0]  step,
   input  logic [ADDR_W-1:0] phase_ofs,
   output logic [ACC_W-1:0]  step_active,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              addr_valid,
   output logic              wrap_pulse,
   output logic              sq_out
);

   localparam logic [3:0] CNT_MAX = 4'(STABLE_N - 1);

   logic [ACC_W-1:0]  step_s1;
   logic [ACC_W-1:0]  step_s2;
   logic [3:0]        stable_cnt;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W:0]    acc_next;
   logic [ADDR_W-1:0] addr_sum;

   always_comb begin
      acc_next = {1'b0, acc} + {1'b0, step_active};
      addr_sum = acc[ACC_W-1 -: ADDR_W] + phase_ofs;
   end

   // A word is accepted only after STABLE_N equal synchronized samples, so
   // torn multi-bit captures of an in-flight change never reach the accumulator.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         step_s1     <= STEP_RESET;
         step_s2     <= STEP_RESET;
         step_active <= STEP_RESET;
         stable_cnt  <= '0;
      end else begin
         step_s1 <= step;
         step_s2 <= step_s1;
         if (step_s1 != step_s2) begin
            stable_cnt <= '0;
         end else if (stable_cnt < CNT_MAX) begin
            stable_cnt <= stable_cnt + 4'd1;
         end else begin
            step_active <= step_s2;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc        <= '0;
         wrap_pulse <= 1'b0;
      end else if (en) begin
         acc        <= acc_next[ACC_W-1:0];
         wrap_pulse <= acc_next[ACC_W];
      end else begin
         wrap_pulse <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rom_addr   <= '0;
         sq_out     <= 1'b0;
         addr_valid <= 1'b0;
      end else begin
         rom_addr   <= addr_sum;
         sq_out     <= addr_sum[ADDR_W-1];
         addr_valid <= en;
      end
   end

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Scoreboard bench for dds_phase_accumulator: directed stimulus pushes
// hand-computed address-stage results, a negedge monitor pops and compares.
module tb_dds_phase_accumulator;

   localparam int unsigned ACC_W    = 32;
   localparam int unsigned ADDR_W   = 10;
   localparam int unsigned STABLE_N = 4;
   localparam logic [31:0] STEP_RST = 32'h0A3D_70A3;

   typedef struct packed {
      logic [9:0] rom;
      logic       sq;
      logic       wrap;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              en;
   logic [ACC_W-1:0]  step;
   logic [ADDR_W-1:0] phase_ofs;
   logic [ACC_W-1:0]  step_active;
   logic [ADDR_W-1:0] rom_addr;
   logic              addr_valid;
   logic              wrap_pulse;
   logic              sq_out;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   dds_phase_accumulator #(
      .ACC_W      (ACC_W),
      .ADDR_W     (ADDR_W),
      .STEP_RESET (STEP_RST),
      .STABLE_N   (STABLE_N)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .step        (step),
      .phase_ofs   (phase_ofs),
      .step_active (step_active),
      .rom_addr    (rom_addr),
      .addr_valid  (addr_valid),
      .wrap_pulse  (wrap_pulse),
      .sq_out      (sq_out)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic push(input int rom, input logic sq, input logic wrap);
      exp_t e;
      e.rom  = rom[9:0];
      e.sq   = sq;
      e.wrap = wrap;
      q.push_back(e);
   endtask

   // Monitor: every valid address-stage output must match the next queued entry.
   always @(negedge clk) begin
      if (addr_valid === 1'b1) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: got rom=%0d sq=%b wrap=%b expected none",
                     rom_addr, sq_out, wrap_pulse);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (rom_addr !== e.rom || sq_out !== e.sq || wrap_pulse !== e.wrap) begin
               n_err++;
               $display("FAIL addr_stage: got rom=%0d sq=%b wrap=%b expected rom=%0d sq=%b wrap=%b at %0t",
                        rom_addr, sq_out, wrap_pulse, e.rom, e.sq, e.wrap, $time);
            end
         end
      end
   end

   task automatic run_en(input int n);
      en = 1'b1;
      repeat (n) @(negedge clk);
      en = 1'b0;
   endtask

   task automatic load_step(input logic [31:0] s, input string name);
      step = s;
      repeat (10) @(negedge clk);
      chk(name, step_active, s);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      reset     = 1'b0;
      en        = 1'b0;
      step      = 32'h1234_5678;
      phase_ofs = '0;

      // Reset defaults
      repeat (3) @(negedge clk);
      chk("rst_step_active", step_active, STEP_RST);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_outs", {29'd0, addr_valid, wrap_pulse, sq_out}, 32'd0);

      // Release: new FCW accepted within STABLE_N+2 cycles, acc untouched
      reset = 1'b1;
      lat = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (step_active == 32'h1234_5678) begin
            lat = c;
            break;
         end
      end
      chk("load_latency_ok", 32'(lat != 0 && lat <= int'(STABLE_N) + 2), 32'd1);
      chk("idle_rom_addr", 32'(rom_addr), 32'd0);
      chk("idle_valid", 32'(addr_valid), 32'd0);

      // Ramp, step = 1/4 turn
      load_step(32'h4000_0000, "load_quarter");
      for (int j = 0; j < 8; j++) push((j % 4) * 256, (j % 4) >= 2, (j % 4) == 3);
      run_en(8);

      // Same ramp with a quarter-turn offset
      phase_ofs = 10'd256;
      push(256, 0, 0); push(512, 1, 0); push(768, 1, 0); push(0, 0, 1);
      push(256, 0, 0); push(512, 1, 0); push(768, 1, 0); push(0, 0, 1);
      run_en(8);

      // Enable dropped: address frozen, wrap idle, valid gone
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("freeze_rom", 32'(rom_addr), 32'd256);
         chk("freeze_wrap_valid", {30'd0, wrap_pulse, addr_valid}, 32'd0);
      end
      phase_ofs = '0;

      // 2-cycle glitch during a running ramp is rejected
      for (int j = 0; j < 15; j++) push((j % 4) * 256, (j % 4) >= 2, (j % 4) == 3);
      en = 1'b1;
      for (int j = 0; j < 15; j++) begin
         @(negedge clk);
         if (j == 4) step = 32'h7FFF_FFFF;
         if (j == 6) step = 32'h4000_0000;
         chk("glitch_step_active", step_active, 32'h4000_0000);
      end
      en = 1'b0;

      // Sustained new FCW loads; phase continues from 0xC0000000
      load_step(32'h7FFF_FFFF, "load_7fff");
      push(768, 1, 1); push(255, 0, 0); push(767, 1, 1); push(255, 0, 0); push(767, 1, 1);
      run_en(5);

      // Zero FCW: acc = 0x3FFFFFFB constant, no wrap
      load_step(32'h0000_0000, "load_zero");
      for (int j = 0; j < 6; j++) push(255, 0, 0);
      run_en(6);

      // Half-turn FCW: alternate X, X+512 with a wrap every second cycle
      load_step(32'h8000_0000, "load_half");
      for (int j = 0; j < 6; j++) push((j % 2) ? 767 : 255, j % 2, j % 2);
      run_en(6);

      // Reset mid-run while a new FCW is still qualifying
      load_step(32'h4000_0000, "load_quarter2");
      push(255, 0, 0); push(511, 0, 0); push(767, 1, 0); push(1023, 1, 1); push(255, 0, 0);
      step = 32'h1111_1111;
      en   = 1'b1;
      repeat (5) @(negedge clk);
      #2;
      reset = 1'b0;
      en    = 1'b0;
      #1;
      chk("async_rst_step", step_active, STEP_RST);
      chk("async_rst_rom", 32'(rom_addr), 32'd0);
      chk("async_rst_outs", {29'd0, addr_valid, wrap_pulse, sq_out}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         chk("requalify_step", step_active, (c < 6) ? STEP_RST : 32'h1111_1111);
      end
      chk("post_rst_rom", 32'(rom_addr), 32'd0);

      repeat (2) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dds_phase_accumulator.md
Name: dds_phase_accumulator

Overview:
- Downstream neighbour of the frequency-control-word generator in the DDS datapath.
- Takes the 32-bit frequency control word (FCW) driven by the pushbutton step logic. That word changes asynchronously to clk, on button edges.
- Captures a stable copy of the FCW and accumulates it every clock into a phase register.
- Emits the waveform ROM address, a square-wave output and a once-per-period wrap pulse for the ROM/DAC stage.
- System clock is 50 MHz, so the default FCW 171798691 gives 2 MHz.

Parameters:
- ACC_W, 32: phase accumulator width; must equal the step port width.
- ADDR_W, 10: waveform ROM address width, taken from the accumulator MSBs.
- STEP_RESET, 171798691: FCW loaded at reset (2 MHz at 50 MHz clk).
- STABLE_N, 4: consecutive equal synchronized samples required before a new FCW is accepted; legal range 2..15.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- en, input, 1: accumulate enable.
- step, input, ACC_W: FCW from the step generator; asynchronous to clk.
- phase_ofs, input, ADDR_W: phase offset added at address resolution.
- step_active, output, ACC_W: FCW currently being accumulated.
- rom_addr, output, ADDR_W: waveform ROM address.
- addr_valid, output, 1: rom_addr was computed from an accumulator value updated under en.
- wrap_pulse, output, 1: single-cycle pulse on accumulator carry-out.
- sq_out, output, 1: MSB of the offset-adjusted phase, i.e. a 50 % square wave.

Behaviour:
- Reset, asserted asynchronously on reset=0:
  - step_s1, step_s2 and step_active are set to STEP_RESET; stable_cnt=0; acc=0.
  - rom_addr=0, addr_valid=0, wrap_pulse=0, sq_out=0.
  - Reset mid-operation discards any FCW that is still qualifying.
- FCW capture (runs every cycle, independent of en):
  - Two-flop synchronizer: step_s1<=step; step_s2<=step_s1.
  - If step_s1!=step_s2, stable_cnt<=0.
  - Else, if stable_cnt<STABLE_N-1, stable_cnt increments.
  - Else (stable_cnt==STABLE_N-1), step_active<=step_s2 and stable_cnt holds.
  - Result: step_active only takes values that held on step for at least STABLE_N consecutive cycles. Torn multi-bit samples and short glitches are rejected.
  - Latency from step settling to step_active update is at most STABLE_N+2 cycles.
  - An FCW change never resets acc, so phase stays continuous across frequency changes.
- Accumulator:
  - When en=1: {carry,acc} <= acc+step_active, modulo 2^ACC_W, and wrap_pulse<=carry.
  - When en=0: acc holds and wrap_pulse<=0.
  - step_active=0 with en=1: acc is constant and wrap_pulse never fires.
  - step_active=2^(ACC_W-1): acc alternates between two values and wrap_pulse fires every second cycle.
- Address stage, registered every cycle with 1 cycle latency from acc:
  - sum = acc[ACC_W-1 -: ADDR_W] + phase_ofs, modulo 2^ADDR_W.
  - rom_addr<=sum; sq_out<=sum[ADDR_W-1]; addr_valid<=en (en delayed one cycle).
- Simultaneous events:
  - A new FCW load and an accumulate in the same cycle: the accumulate uses the old step_active; the new value applies from the next cycle.
  - A phase_ofs change takes effect on the next rom_addr with no qualification; phase_ofs is a clk-domain signal.

Test Plan:
- Reset defaults: hold reset=0 with step=0x12345678 → all outputs at reset values, step_active=171798691. Release reset, en=0, step held → step_active=0x12345678 within STABLE_N+2 cycles; acc and rom_addr stay 0.
- Ramp: step=0x40000000 held and loaded, phase_ofs=0, en=1.
  - rom_addr sequence: 0, 256, 512, 768, 0, …
  - sq_out: 0, 0, 1, 1, repeating.
  - wrap_pulse high exactly on the cycle each wrap occurs, every 4th cycle.
  - addr_valid=1 from the cycle after en rises.
- Offset: repeat the ramp with phase_ofs=256 → rom_addr 256, 512, 768, 0; sq_out shifted by one cycle; wrap_pulse timing unchanged.
- Glitch rejection: from a loaded step=0x40000000, drive step=0x7FFFFFFF for 2 cycles, then back → step_active never changes and the ramp continues unbroken. Hold 0x7FFFFFFF for 10 cycles → step_active updates and acc continues from its current value with no jump.
- Enable and edge FCWs:
  - en=0 mid-ramp: rom_addr freezes, wrap_pulse=0, addr_valid falls one cycle later.
  - step=0: rom_addr constant and no wrap.
  - step=0x80000000: rom_addr alternates X, X+512.
- Reset mid-run: assert reset during an active ramp, with a new step still qualifying → outputs clear immediately, asynchronously. step_active=STEP_RESET after release; the pending value is loaded only after a fresh STABLE_N qualification.
